// File: rtl/simplez_kbd_if.sv
// CPU-side register bus of the Simplez keyboard receiver.
// The CPU drives address and read strobe; the peripheral returns read data and a byte-available flag.
interface simplez_kbd_if;
  logic [8:0]  addr;
  logic        rd;
  logic [11:0] data_out;
  logic        rx_ready;

  modport master (output addr, output rd, input data_out, input rx_ready);
  modport slave  (input addr, input rd, output data_out, output rx_ready);
endinterface

// File: rtl/simplez_kbd.sv
// Simplez keyboard peripheral: 8N1 UART receiver feeding a small byte FIFO,
// read by the CPU through a status register and a consuming data register.
`ifndef B115200
`define B115200 104
`endif

module simplez_kbd #(
  parameter int         BAUD           = `B115200,
  parameter int         DEPTH          = 4,
  parameter logic [8:0] KBD_STATUS_ADR = 9'd507,
  parameter logic [8:0] KBD_DATA_ADR   = 9'd508
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         rx,
  simplez_kbd_if.slave bus
);

  localparam int HALF = BAUD / 2;
  localparam int CW   = $clog2(BAUD);
  localparam int AW   = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_nx;
  logic          rx_meta, rxs;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tick, push, ferr_set, shift_en;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          empty, full, pop, push_ok, ovr_set, flag_clr;
  logic          overrun, framing;
  logic [11:0]   status;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Start bit is checked at mid-bit; every later sample lands one full bit period further on.
  always_comb begin
    tick = 1'b0;
    case (state)
      START:      tick = (baud_cnt == CW'(HALF - 1));
      DATA, STOP: tick = (baud_cnt == CW'(BAUD - 1));
      default:    tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!rxs) state_nx = START;
      START:   if (tick) state_nx = rxs ? IDLE : DATA;
      DATA:    if (tick && bit_cnt == 3'd7) state_nx = STOP;
      STOP:    if (tick) state_nx = rxs ? IDLE : BREAK;
      BREAK:   if (rxs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    push     = (state == STOP) && tick && rxs;
    ferr_set = (state == STOP) && tick && !rxs;
    shift_en = (state == DATA) && tick;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      if (state == IDLE || state == BREAK || tick) baud_cnt <= '0;
      else                                         baud_cnt <= baud_cnt + 1'b1;
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift <= {rxs, shift[7:1]};
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = bus.rd && (bus.addr == KBD_DATA_ADR) && !empty;
  assign push_ok  = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign flag_clr = bus.rd && (bus.addr == KBD_STATUS_ADR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      if (ovr_set)       overrun <= 1'b1;
      else if (flag_clr) overrun <= 1'b0;
      if (ferr_set)      framing <= 1'b1;
      else if (flag_clr) framing <= 1'b0;
    end
  end

  assign status       = {{(7 - AW){1'b0}}, count, framing, overrun, full, !empty};
  assign bus.rx_ready = !empty;

  always_comb begin
    bus.data_out = 12'h000;
    if (bus.addr == KBD_STATUS_ADR)
      bus.data_out = status;
    else if (bus.addr == KBD_DATA_ADR && !empty)
      bus.data_out = {4'b0000, mem[rd_ptr[AW-1:0]]};
  end

endmodule

// File: doc/simplez_kbd.md
# simplez_kbd

Memory-mapped serial receive peripheral for the Simplez processor: the input counterpart of the screen transmitter. It deserialises 8N1 UART frames from the host (keyboard) line, buffers the received bytes in a small FIFO and exposes them to the CPU through two read-only registers in the 1F8–1FF peripheral window. A byte is consumed when the CPU reads the data register with a read strobe. Sticky error flags report overrun and framing faults.

## Interface
- `BAUD`, default `` `B115200 `` (clock cycles per bit, 104 at 12 MHz): bit period; must be ≥ 8.
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `KBD_STATUS_ADR`, default 9'd507: status register address.
- `KBD_DATA_ADR`, default 9'd508: data register address.
- `clk` in 1: system clock.
- `rstn` in 1: reset, active-low, asynchronous assert; one clock, all state reset asynchronously.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `addr` in 9: CPU address bus.
- `rd` in 1: one-cycle read-consume strobe; acts only when `addr` selects a register in the same cycle.
- `data_out` out 12: register read data, combinational from `addr` and internal state; 0 when `addr` selects neither register.
- `rx_ready` out 1: FIFO not empty; reset 0.

## Operation
- Synchroniser: `rx` passes through two flops, reset value 1; all logic uses the synchronised line `rxs`.
- Receiver FSM, states IDLE, START, DATA, STOP, BREAK; reset to IDLE, counters 0, shift register 0.
  - IDLE: `rxs`==0 → START, bit counter cleared.
  - START: wait BAUD/2 cycles (integer division); sample: 0 → DATA, 1 → IDLE (glitch, nothing recorded).
  - DATA: wait BAUD cycles, sample, shift in LSB first; after 8th bit → STOP.
  - STOP: wait BAUD cycles, sample: 1 → push byte, → IDLE; 0 → set framing flag, drop byte, → BREAK.
  - BREAK: wait until `rxs`==1 → IDLE.
- FIFO: DEPTH × 8 bits, read/write pointers with one extra wrap bit; full when pointers differ only in the wrap bit, empty when equal; both pointers wrap modulo DEPTH.
  - Push accepted if not full, or if a pop occurs in the same cycle. Otherwise byte dropped, overrun flag set, contents unchanged.
  - Pop = `rd` & `addr`==KBD_DATA_ADR & not empty. Pop while empty is ignored.
- Data register: {4'b0, head byte}; 12'h000 when empty.
- Status register: bit0 not-empty, bit1 full, bit2 overrun (sticky), bit3 framing error (sticky), bits[11:4] current entry count, zero-extended.
- `rd` with `addr`==KBD_STATUS_ADR clears both sticky flags. If a flag is set in the same cycle, the set wins.
- `rstn` low mid-frame: the frame is abandoned, FIFO emptied, flags cleared. After release the receiver waits in IDLE for the next falling edge, so a line that is still low restarts reception immediately. Bench waits for idle.

## Timing
- Synchroniser latency: 2 cycles from `rx` edge to `rxs`.
- Push cycle: BAUD/2 + 9·BAUD cycles after START entry (988 for BAUD=104). `rx_ready` and count update the following cycle.
- Pop: `data_out` shows the next head in the cycle after the `rd` strobe. `rx_ready` falls in the cycle after the last byte is popped.
- Back-to-back frames: a new start bit is accepted in the cycle after STOP returns to IDLE; there are no dead cycles beyond that.
- `data_out` has no registered latency: a valid `addr` is readable in the same cycle, as the CPU's LD EXEC2 sample requires.

## Test plan
- Reset: `rstn`=0 with `rx`=1 → `rx_ready`=0; status read = 12'h000; data read = 12'h000.
- Single frame 0x41, BAUD=104 → push within 990±2 cycles of the falling edge; status = 12'h011; data read = 12'h041. After `rd` on data, `rx_ready`=0 and status = 12'h000.
- Five frames 0x01..0x05 with DEPTH=4 and no reads → status = 12'h047 (count 4, full, overrun). Reads return 0x01..0x04. A status read with `rd` then yields 12'h000.
- Framing: frame 0x55 with stop bit 0, line low for 3 bit times, then high → byte not stored; status bit3=1. A following good frame 0x33 is received correctly.
- Glitch: `rx` low for BAUD/4 cycles → no push, no flags, FSM back in IDLE.
- Simultaneous: FIFO full, push cycle coincides with a data-register `rd` → pop and push both occur; count stays 4; overrun stays 0.
